// File: rtl/param_register_file_if.sv
// Register-file bus: write port, packed read ports and bulk-clear handshake.
// The datapath side uses the master modport; the register file uses slave.
interface param_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic                           regWrite;
    logic [ADDR_WIDTH-1:0]          destReg;
    logic [DATA_WIDTH-1:0]          writeData;
    logic [NUM_READ*ADDR_WIDTH-1:0] srcRegs;
    logic [NUM_READ*DATA_WIDTH-1:0] outBus;
    logic                           clearReq;
    logic                           clearBusy;
    logic                           clearDone;
    logic                           writeStall;

    modport master (
        output regWrite, destReg, writeData, srcRegs, clearReq,
        input  outBus, clearBusy, clearDone, writeStall
    );

    modport slave (
        input  regWrite, destReg, writeData, srcRegs, clearReq,
        output outBus, clearBusy, clearDone, writeStall
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised decode-stage register file: N combinational read ports, one write
// port, optional hardwired-zero r0, optional write bypass and a bulk-clear engine.
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    param_register_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clearState_e;

    clearState_e           state;
    clearState_e           nextState;
    logic [ADDR_WIDTH-1:0] clearPtr;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  writeAccept;

    // Writes to r0 are discarded when it is hardwired, so they never bypass either.
    assign writeAccept = bus.regWrite && (state == IDLE) &&
                         !((ZERO_REG != 0) && (bus.destReg == '0));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clearPtr <= '0;
        end else begin
            state <= nextState;
            if (state == CLEAR && clearPtr != LAST_IDX) begin
                clearPtr <= clearPtr + ADDR_WIDTH'(1);
            end else begin
                clearPtr <= '0;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.clearReq) nextState = CLEAR;
            CLEAR:   if (clearPtr == LAST_IDX) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: the array is reset deliberately; an asynchronous full zero is part of
    // the block's contract, so this storage is built from flops, not a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[clearPtr] <= '0;
        end else if (writeAccept) begin
            regs[bus.destReg] <= bus.writeData;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : gRead
        logic [ADDR_WIDTH-1:0] readIdx;
        logic                  zeroHit;
        logic                  bypassHit;

        assign readIdx   = bus.srcRegs[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign zeroHit   = (ZERO_REG != 0) && (readIdx == '0);
        assign bypassHit = (BYPASS != 0) && writeAccept && (readIdx == bus.destReg);

        assign bus.outBus[k*DATA_WIDTH +: DATA_WIDTH] =
            zeroHit   ? '0 :
            bypassHit ? bus.writeData :
                        regs[readIdx];
    end

    assign bus.clearBusy  = (state != IDLE);
    assign bus.clearDone  = (state == DONE);
    assign bus.writeStall = (state != IDLE);
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default build plus no-zero-reg,
// no-bypass and narrow four-port variants sharing one clock and reset.
module tb_param_register_file;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    param_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) busA ();
    param_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) busNz ();
    param_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) busNb ();
    param_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4)) busS ();

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1))
        dutA (.clk(clk), .reset(reset), .bus(busA));
    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(1))
        dutNz (.clk(clk), .reset(reset), .bus(busNz));
    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(0))
        dutNb (.clk(clk), .reset(reset), .bus(busNb));
    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4), .ZERO_REG(1), .BYPASS(1))
        dutS (.clk(clk), .reset(reset), .bus(busS));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        busA.srcRegs = {5'd3, 5'd1};
        busS.srcRegs = {3'd7, 3'd5, 3'd3, 3'd1};
        @(negedge clk);
        #1;
        checks++;
        if (busA.clearBusy !== 1'b0 || busA.clearDone !== 1'b0 || busA.writeStall !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b stall=%b want 0 0 0",
                     busA.clearBusy, busA.clearDone, busA.writeStall);
        end
        checks++;
        if (busA.outBus !== 64'h0) begin
            errors++;
            $display("FAIL reset_read: got %h want 0", busA.outBus);
        end
        checks++;
        if (busS.outBus !== 64'h0 || busS.clearBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: got out=%h busy=%b want 0 0", busS.outBus, busS.clearBusy);
        end
        reset = 1'b1;
    endtask

    task automatic test_readback();
        for (int i = 2; i <= 8; i += 2) begin
            @(negedge clk);
            busA.regWrite  = 1'b1;
            busA.destReg   = 5'(i);
            busA.writeData = 32'(i);
        end
        @(negedge clk);
        busA.regWrite = 1'b0;
        busA.srcRegs  = {5'd8, 5'd2};
        #1;
        checks++;
        if (busA.outBus !== {32'd8, 32'd2}) begin
            errors++;
            $display("FAIL readback_8_2: got %h want %h", busA.outBus, {32'd8, 32'd2});
        end
        busA.srcRegs = {5'd6, 5'd4};
        #1;
        checks++;
        if (busA.outBus !== {32'd6, 32'd4}) begin
            errors++;
            $display("FAIL readback_6_4: got %h want %h", busA.outBus, {32'd6, 32'd4});
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        busA.regWrite   = 1'b1;
        busA.destReg    = 5'd0;
        busA.writeData  = 32'hDEADBEEF;
        busA.srcRegs    = {5'd0, 5'd0};
        busNz.regWrite  = 1'b1;
        busNz.destReg   = 5'd0;
        busNz.writeData = 32'hDEADBEEF;
        busNz.srcRegs   = {5'd0, 5'd0};
        #1;
        checks++;
        if (busA.outBus[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL zero_no_bypass: got %h want 0", busA.outBus[31:0]);
        end
        checks++;
        if (busNz.outBus[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL nozero_bypass: got %h want deadbeef", busNz.outBus[31:0]);
        end
        @(negedge clk);
        busA.regWrite  = 1'b0;
        busNz.regWrite = 1'b0;
        #1;
        checks++;
        if (busA.outBus[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_read: got %h want 0", busA.outBus[31:0]);
        end
        checks++;
        if (busNz.outBus[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL nozero_read: got %h want deadbeef", busNz.outBus[31:0]);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        busA.regWrite  = 1'b1;
        busA.destReg   = 5'd5;
        busA.writeData = 32'h55;
        busA.srcRegs   = {5'd5, 5'd5};
        busNb.regWrite  = 1'b1;
        busNb.destReg   = 5'd5;
        busNb.writeData = 32'h55;
        busNb.srcRegs   = {5'd5, 5'd5};
        #1;
        checks++;
        if (busA.outBus !== {32'h55, 32'h55}) begin
            errors++;
            $display("FAIL bypass_both: got %h want %h", busA.outBus, {32'h55, 32'h55});
        end
        checks++;
        if (busNb.outBus !== 64'h0) begin
            errors++;
            $display("FAIL nobypass_old: got %h want 0", busNb.outBus);
        end
        @(negedge clk);
        busA.regWrite  = 1'b0;
        busNb.regWrite = 1'b0;
        #1;
        checks++;
        if (busNb.outBus !== {32'h55, 32'h55}) begin
            errors++;
            $display("FAIL nobypass_after: got %h want %h", busNb.outBus, {32'h55, 32'h55});
        end
    endtask

    task automatic test_bulk_clear();
        int busy;
        int doneCnt;
        int doneAt;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            busA.regWrite  = 1'b1;
            busA.destReg   = 5'(i);
            busA.writeData = 32'h1000 + 32'(i);
        end
        @(negedge clk);
        busA.regWrite = 1'b0;
        busA.clearReq = 1'b1;
        busA.srcRegs  = {5'd31, 5'd1};
        #1;
        checks++;
        if (busA.outBus !== {32'h101F, 32'h1001}) begin
            errors++;
            $display("FAIL fill_read: got %h want %h", busA.outBus, {32'h101F, 32'h1001});
        end
        busy = 0;
        doneCnt = 0;
        doneAt = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            busA.clearReq = 1'b0;
            busA.regWrite = 1'b0;
            busA.srcRegs  = {5'd31, 5'd1};
            if (cyc == 5) begin
                busA.regWrite  = 1'b1;
                busA.destReg   = 5'd3;
                busA.writeData = 32'h77;
                busA.srcRegs   = {5'd1, 5'd3};
            end
            if (cyc == 11) busA.srcRegs = {5'd10, 5'd9};
            #1;
            if (busA.clearBusy) busy++;
            if (busA.clearDone) begin
                doneCnt++;
                doneAt = cyc;
            end
            if (cyc == 5) begin
                checks++;
                if (busA.writeStall !== 1'b1 || busA.outBus !== 64'h0) begin
                    errors++;
                    $display("FAIL stall_write: got stall=%b out=%h want 1 0", busA.writeStall, busA.outBus);
                end
            end
            if (cyc == 11) begin
                checks++;
                if (busA.outBus !== {32'h100A, 32'h0}) begin
                    errors++;
                    $display("FAIL partial_clear: got %h want %h", busA.outBus, {32'h100A, 32'h0});
                end
            end
            if (!busA.clearBusy) break;
        end
        checks++;
        if (busy != 33 || doneCnt != 1 || doneAt != 33) begin
            errors++;
            $display("FAIL clear_timing: got busy=%0d done=%0d at %0d want 33 1 33", busy, doneCnt, doneAt);
        end
        for (int i = 0; i < 32; i += 2) begin
            busA.srcRegs = {5'(i + 1), 5'(i)};
            #1;
            checks++;
            if (busA.outBus !== 64'h0) begin
                errors++;
                $display("FAIL cleared_%0d: got %h want 0", i, busA.outBus);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int spurious;
        @(negedge clk);
        busA.regWrite  = 1'b1;
        busA.destReg   = 5'd20;
        busA.writeData = 32'h1234;
        @(negedge clk);
        busA.regWrite = 1'b0;
        busA.clearReq = 1'b1;
        busA.srcRegs  = {5'd20, 5'd20};
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            busA.clearReq = 1'b0;
        end
        #1;
        checks++;
        if (busA.clearBusy !== 1'b1 || busA.outBus[31:0] !== 32'h1234) begin
            errors++;
            $display("FAIL midclear_pre: got busy=%b out=%h want 1 1234", busA.clearBusy, busA.outBus[31:0]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busA.clearBusy !== 1'b0 || busA.clearDone !== 1'b0 || busA.outBus !== 64'h0) begin
            errors++;
            $display("FAIL midclear_reset: got busy=%b done=%b out=%h want 0 0 0",
                     busA.clearBusy, busA.clearDone, busA.outBus);
        end
        @(negedge clk);
        reset = 1'b1;
        spurious = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            #1;
            if (busA.clearDone || busA.clearBusy) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midclear_no_done: got %0d active cycles want 0", spurious);
        end
        @(negedge clk);
        busA.regWrite  = 1'b1;
        busA.destReg   = 5'd20;
        busA.writeData = 32'hCAFE;
        @(negedge clk);
        busA.regWrite = 1'b0;
        #1;
        checks++;
        if (busA.outBus[31:0] !== 32'hCAFE) begin
            errors++;
            $display("FAIL midclear_write: got %h want cafe", busA.outBus[31:0]);
        end
    endtask

    task automatic test_param_build();
        int busy;
        int doneAt;
        @(negedge clk);
        busS.regWrite  = 1'b1;
        busS.destReg   = 3'd7;
        busS.writeData = 16'hABCD;
        @(negedge clk);
        busS.regWrite = 1'b0;
        busS.srcRegs  = {3'd1, 3'd0, 3'd7, 3'd7};
        #1;
        checks++;
        if (busS.outBus !== {16'h0, 16'h0, 16'hABCD, 16'hABCD}) begin
            errors++;
            $display("FAIL small_read: got %h want %h", busS.outBus, {16'h0, 16'h0, 16'hABCD, 16'hABCD});
        end
        busS.clearReq = 1'b1;
        busy = 0;
        doneAt = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            busS.clearReq = 1'b0;
            #1;
            if (busS.clearBusy) busy++;
            if (busS.clearDone) doneAt = cyc;
            if (!busS.clearBusy) break;
        end
        checks++;
        if (busy != 9 || doneAt != 9) begin
            errors++;
            $display("FAIL small_clear_timing: got busy=%0d done at %0d want 9 9", busy, doneAt);
        end
        checks++;
        if (busS.outBus !== 64'h0) begin
            errors++;
            $display("FAIL small_cleared: got %h want 0", busS.outBus);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        busA.regWrite = 1'b0;  busA.destReg = '0;  busA.writeData = '0;  busA.srcRegs = '0;  busA.clearReq = 1'b0;
        busNz.regWrite = 1'b0; busNz.destReg = '0; busNz.writeData = '0; busNz.srcRegs = '0; busNz.clearReq = 1'b0;
        busNb.regWrite = 1'b0; busNb.destReg = '0; busNb.writeData = '0; busNb.srcRegs = '0; busNb.clearReq = 1'b0;
        busS.regWrite = 1'b0;  busS.destReg = '0;  busS.writeData = '0;  busS.srcRegs = '0;  busS.clearReq = 1'b0;
        test_reset();
        test_readback();
        test_zero_reg();
        test_bypass();
        test_bulk_clear();
        test_reset_mid_clear();
        test_param_build();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
